uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters, 2..8.
REQ-002 Parameter UART_BASE, default 32'h4000_0000: APB base of UART0 (DATA +0x0, STATUS +0x4, CTRL +0x8, SCALER +0xC).
REQ-003 Parameter SCALER_VAL, default 32'd53: scaler init value (115200 baud at 50 MHz).
REQ-004 Parameter CTRL_VAL, default 32'h0000_008F: CTRL init value.
REQ-005 Parameter POLL_LIMIT, default 1023: maximum STATUS polls per byte.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 PCLK  input  1  block clock, all logic on rising edge.
REQ-008 PRESET  input  1  synchronous active-high reset.
REQ-009 req_valid  input  N_REQ  per-requester byte-pending flag.
REQ-010 req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i].
REQ-011 req_ready  output  N_REQ  one-cycle accept pulse; at most one bit set.
REQ-012 PADDR  output  32  APB master address.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-014 PWDATA  output  32  APB write data.
REQ-015 PRDATA  input  32  APB read data.
REQ-016 PREADY  input  1  APB ready; low inserts wait states.
REQ-017 init_done  output  1  high once UART init writes complete.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 grant_id  output  3  index of requester whose byte is in flight.
REQ-020 err  output  1  one-cycle pulse on poll timeout.

Function
REQ-021 FSM states: INIT_SETUP, INIT_ACCESS, IDLE, POLL_SETUP, POLL_ACCESS, WR_SETUP, WR_ACCESS.
REQ-022 APB: SETUP drives PSEL=1, PENABLE=0; ACCESS drives PSEL=1, PENABLE=1 and holds PADDR/PWRITE/PWDATA until PREADY=1; the cycle after completion PSEL=0 unless the next state is a SETUP.
REQ-023 INIT writes, in order: SCALER<=SCALER_VAL, CTRL<=CTRL_VAL, STATUS<=0; a 2-bit index selects each; after the third completes, init_done=1 and state goes to IDLE.
REQ-024 IDLE: if any req_valid, the round-robin winner gets req_ready=1 that same cycle, req_data byte is latched, grant_id updated, next state POLL_SETUP; otherwise stay.
REQ-025 Round-robin: search starts at (last_grant+1) mod N_REQ; pointer updates only on accept; after reset search starts at 0.
REQ-026 POLL reads STATUS; on PREADY sample PRDATA[2] (TE): 1 -> WR_SETUP; 0 -> increment poll counter and return to POLL_SETUP.
REQ-027 Poll counter reaching POLL_LIMIT with TE=0: byte dropped, err pulses one cycle, state IDLE; counter clears on every accept.
REQ-028 WR writes {24'b0, byte} to DATA; on PREADY go to IDLE.
REQ-029 Minimum accept-to-accept spacing with zero-wait slave and TE=1: 5 cycles.
REQ-030 req_valid dropping while not granted is ignored; no request is queued internally.
REQ-031 PRDATA bits other than [2] are ignored.

Reset
REQ-032 PRESET sampled high, at any state including mid-APB transfer: next edge PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, err=0, busy=1, init_done=0, grant_id=0, RR pointer=N_REQ-1, state INIT_SETUP (IDLE without the macro).

Configuration
REQ-033 Macro UART_TX_SCHED_INIT_EN defined: INIT states and init sequence compiled in as REQ-023.
REQ-034 Macro absent: INIT logic removed; reset enters IDLE; init_done is tied 1; software configures UART.

Structure
REQ-035 Package uart_tx_sched_pkg: FSM state enum, register offsets DATA/STATUS/CTRL/SCALER, STATUS bit indices TS=1, TE=2.
REQ-036 One sub-module uart_tx_rr_arb: combinational N_REQ round-robin winner plus registered pointer.

Verification
REQ-037 Reset, macro on -> writes SCALER=53, CTRL=0x8F, STATUS=0 in order; init_done rises after third PREADY.
REQ-038 req_valid[0] with 0x55, slave STATUS=0x4 -> req_ready[0] pulse, STATUS read, DATA write 0x55, then IDLE; 5 cycles.
REQ-039 All four valid continuously, data 0x10..0x13 -> DATA order 0x10,0x11,0x12,0x13,0x10; no requester granted twice consecutively.
REQ-040 STATUS TE=0 for 3 reads then 1, PREADY low 2 cycles each access -> 4 reads, one write, transfers stretched correctly.
REQ-041 TE stuck 0 with POLL_LIMIT=4 -> 4 reads, err one pulse, no DATA write, returns IDLE.
REQ-042 PRESET asserted during WR_ACCESS with PREADY low -> PSEL=0 next edge, init sequence restarts, no DATA write completes.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_pkg
// Description : Shared FSM encodings, UART register map and APB drive struct.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT_SETUP  = 3'd0;
    localparam state_t ST_INIT_ACCESS = 3'd1;
    localparam state_t ST_IDLE        = 3'd2;
    localparam state_t ST_POLL_SETUP  = 3'd3;
    localparam state_t ST_POLL_ACCESS = 3'd4;
    localparam state_t ST_WR_SETUP    = 3'd5;
    localparam state_t ST_WR_ACCESS   = 3'd6;

    localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;
    localparam logic [31:0] OFS_SCALER = 32'h0000_000C;

    localparam int TS_BIT = 1;
    localparam int TE_BIT = 2;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } apb_drv_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Requester handshake plus APB master bus of the UART TX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  req_valid, req_data, PRDATA, PREADY,
        output req_ready, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_data, PRDATA, PREADY,
        input  req_ready, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_rr_arb
// Description : Combinational round-robin winner with a registered last-grant pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_rr_arb #(
    parameter int N_REQ = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic             accept_i,
    output logic      [N_REQ-1:0] gnt_o,
    output logic      [2:0]       gnt_id_o,
    output logic                  any_o
);

    logic [2:0]       ptr_q;
    logic [3:0]       idx;
    logic [N_REQ-1:0] sh;

    // Search starts one past the last grant and wraps modulo N_REQ.
    always_comb begin
        any_o    = 1'b0;
        gnt_id_o = '0;
        idx      = '0;
        sh       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(N_REQ)) begin
                idx = idx - 4'(N_REQ);
            end
            sh = req_i >> idx;
            if (!any_o && sh[0]) begin
                any_o    = 1'b1;
                gnt_id_o = idx[2:0];
            end
        end
    end

    assign gnt_o = any_o ? (N_REQ'(1) << gnt_id_o) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 3'(N_REQ - 1);
        end else if (accept_i && any_o) begin
            ptr_q <= gnt_id_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin byte scheduler feeding a UART over APB with TE polling.
//               Define UART_TX_SCHED_INIT_EN to include the UART init sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int          N_REQ      = 4,
    parameter logic [31:0] UART_BASE  = 32'h4000_0000,
    parameter logic [31:0] SCALER_VAL = 32'd53,
    parameter logic [31:0] CTRL_VAL   = 32'h0000_008F,
    parameter int          POLL_LIMIT = 1023
) (
    input  wire logic       PCLK,
    input  wire logic       PRESET,
    uart_tx_sched_if.master bus,
    output logic            init_done,
    output logic            busy,
    output logic [2:0]      grant_id,
    output logic            err
);

    localparam int            CW       = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(POLL_LIMIT - 1);
`ifdef UART_TX_SCHED_INIT_EN
    localparam state_t        RST_STATE = ST_INIT_SETUP;
`else
    localparam state_t        RST_STATE = ST_IDLE;
`endif

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [CW-1:0]    poll_q, poll_d;
    logic [2:0]       gid_q, gid_d;
    apb_drv_t         apb_q, apb_d;
`ifdef UART_TX_SCHED_INIT_EN
    logic [1:0]       idx_q, idx_d;
    logic             done_q, done_d;
`endif

    logic [N_REQ-1:0] w_gnt;
    logic [2:0]       w_gnt_id;
    logic             w_any;
    logic             w_accept;
    logic [7:0]       w_byte;
    logic             w_te;
    logic             w_unused_prdata;

    uart_tx_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .req_i    (bus.req_valid),
        .accept_i (w_accept),
        .gnt_o    (w_gnt),
        .gnt_id_o (w_gnt_id),
        .any_o    (w_any)
    );

    assign w_accept        = (state_q == ST_IDLE) && w_any;
    assign w_te            = bus.PRDATA[TE_BIT];
    assign w_unused_prdata = &{1'b0, bus.PRDATA[31:TE_BIT+1], bus.PRDATA[TS_BIT], bus.PRDATA[0]};

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        poll_d  = poll_q;
        gid_d   = gid_q;
        err     = 1'b0;
`ifdef UART_TX_SCHED_INIT_EN
        idx_d   = idx_q;
        done_d  = done_q;
`endif
        case (state_q)
`ifdef UART_TX_SCHED_INIT_EN
            // The cycle right after reset has PSEL low; wait for the setup phase to be on the bus.
            ST_INIT_SETUP: begin
                if (apb_q.psel) begin
                    state_d = ST_INIT_ACCESS;
                end
            end
            ST_INIT_ACCESS: begin
                if (bus.PREADY) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_INIT_SETUP;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (w_accept) begin
                    byte_d  = w_byte;
                    gid_d   = w_gnt_id;
                    poll_d  = '0;
                    state_d = ST_POLL_SETUP;
                end
            end
            ST_POLL_SETUP:  state_d = ST_POLL_ACCESS;
            ST_POLL_ACCESS: begin
                if (bus.PREADY) begin
                    if (w_te) begin
                        state_d = ST_WR_SETUP;
                    end else if (poll_q == CNT_LAST) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        poll_d  = poll_q + 1'b1;
                        state_d = ST_POLL_SETUP;
                    end
                end
            end
            ST_WR_SETUP:    state_d = ST_WR_ACCESS;
            ST_WR_ACCESS: begin
                if (bus.PREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default:        state_d = RST_STATE;
        endcase
    end

    // Bus drive is registered from the next state so the outputs match state_q except right after reset.
    always_comb begin
        apb_d = '0;
        case (state_d)
`ifdef UART_TX_SCHED_INIT_EN
            ST_INIT_SETUP, ST_INIT_ACCESS: begin
                apb_d.psel    = 1'b1;
                apb_d.penable = (state_d == ST_INIT_ACCESS);
                apb_d.pwrite  = 1'b1;
                case (idx_d)
                    2'd0: begin
                        apb_d.paddr  = UART_BASE + OFS_SCALER;
                        apb_d.pwdata = SCALER_VAL;
                    end
                    2'd1: begin
                        apb_d.paddr  = UART_BASE + OFS_CTRL;
                        apb_d.pwdata = CTRL_VAL;
                    end
                    default: begin
                        apb_d.paddr  = UART_BASE + OFS_STATUS;
                        apb_d.pwdata = '0;
                    end
                endcase
            end
`endif
            ST_POLL_SETUP, ST_POLL_ACCESS: begin
                apb_d.psel    = 1'b1;
                apb_d.penable = (state_d == ST_POLL_ACCESS);
                apb_d.paddr   = UART_BASE + OFS_STATUS;
            end
            ST_WR_SETUP, ST_WR_ACCESS: begin
                apb_d.psel    = 1'b1;
                apb_d.penable = (state_d == ST_WR_ACCESS);
                apb_d.pwrite  = 1'b1;
                apb_d.paddr   = UART_BASE + OFS_DATA;
                apb_d.pwdata  = {24'b0, byte_d};
            end
            default: apb_d = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= RST_STATE;
            byte_q  <= '0;
            poll_q  <= '0;
            gid_q   <= '0;
            apb_q   <= '0;
`ifdef UART_TX_SCHED_INIT_EN
            idx_q   <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            poll_q  <= poll_d;
            gid_q   <= gid_d;
            apb_q   <= apb_d;
`ifdef UART_TX_SCHED_INIT_EN
            idx_q   <= idx_d;
            done_q  <= done_d;
`endif
        end
    end

    assign bus.PSEL      = apb_q.psel;
    assign bus.PENABLE   = apb_q.penable;
    assign bus.PWRITE    = apb_q.pwrite;
    assign bus.PADDR     = apb_q.paddr;
    assign bus.PWDATA    = apb_q.pwdata;
    assign bus.req_ready = w_accept ? w_gnt : '0;

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = gid_q;
`ifdef UART_TX_SCHED_INIT_EN
    assign init_done = done_q;
`else
    assign init_done = 1'b1;
`endif

endmodule
`default_nettype wire
